serial_adder_ctrl: RTL
======================

SERIAL_ADDER_CTRL -- requirements
Module: serial_adder_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning operand/result width in bits (legal 2..32).
REQ-002 SHALL have port sys_clk, input, 1, meaning the single system clock; all state changes on its rising edge.
REQ-003 SHALL have port sys_rst_n, input, 1, meaning reset, asynchronous and active-low.
REQ-004 SHALL have port start, input, 1, meaning request one addition; sampled only in IDLE or DONE.
REQ-005 SHALL have ports op_a and op_b, input, WIDTH, meaning the two addends, captured on the accepted start.
REQ-006 SHALL have port cin, input, 1, meaning the initial carry-in, captured on the accepted start.
REQ-007 SHALL have port busy, output, 1, meaning high while in SHIFT.
REQ-008 SHALL have port done, output, 1, meaning a one-cycle pulse when the result becomes valid.
REQ-009 SHALL have port sum, output, WIDTH, meaning the result, held stable from done until the next accepted start.
REQ-010 SHALL have port count, output, 1, meaning the final carry-out, held together with sum.

Function
REQ-011 SHALL compute {count,sum} = op_a + op_b + cin bit-serially, LSB first, one bit per cycle through a single 1-bit full adder.
REQ-012 SHALL implement the FSM states IDLE, SHIFT and DONE.
REQ-013 SHALL follow these transitions: IDLE->SHIFT on start; SHIFT->DONE after WIDTH bit cycles; DONE->SHIFT on start, else DONE->IDLE.
REQ-014 SHALL, on the accepted start (cycle 0), load the operand shift registers and the carry register from op_a, op_b and cin, clear the bit counter, and leave sum and count unchanged until done.
REQ-015 SHALL, in SHIFT cycles 1..WIDTH, feed bit k-1 and the carry register to the adder in cycle k, shift the sum bit into the result register MSB-side, and register the adder's carry.
REQ-016 SHALL assert done in cycle WIDTH+1 (state DONE), with sum and count valid in that same cycle; latency from start to done is WIDTH+1 cycles.
REQ-017 SHALL ignore start while busy=1, keeping the operands and the operation in progress unaffected.
REQ-018 SHALL discard any carry beyond count (no wrap into sum); op_a=op_b=all-ones with cin=1 yields sum=all-ones and count=1.
REQ-019 SHALL keep the bit counter at ceil(log2(WIDTH+1)) bits, with no wrap-around before the terminal value WIDTH.
REQ-020 SHALL keep busy and done mutually exclusive in every cycle.

Reset
REQ-021 SHALL, on sys_rst_n low at any time, go to state IDLE and drive busy=0, done=0, sum=0 and count=0, and clear the carry register, shift registers and counter.
REQ-022 SHALL, on reset mid-operation, abort the operation with no done pulse; the first start after release begins a fresh operation.

Configuration
REQ-023 SHALL, with macro SERIAL_ADDER_SUB_EN defined, add input port sub (1 bit, captured on start); when sub=1 it loads ~op_b and forces the carry-in to 1, so that sum=op_a-op_b, count=1 when there is no borrow, and cin is ignored.
REQ-024 SHALL, without SERIAL_ADDER_SUB_EN, omit port sub and perform addition only.

Structure
REQ-025 SHALL place the state encoding (IDLE/SHIFT/DONE localparams) and the default WIDTH constant in the shared package serial_adder_pkg.
REQ-026 SHALL instantiate exactly one sub-module, full_adder (inputs in_1, in_2, cin; outputs sum, count), as the per-bit datapath; it contains no other arithmetic.

Verification
REQ-027 SHALL verify, at WIDTH=8: op_a=8'h0F, op_b=8'h01, cin=0, start at cycle 0 -> busy in cycles 1-8, done=1 in cycle 9, sum=8'h10, count=0.
REQ-028 SHALL verify: op_a=8'hFF, op_b=8'h01, cin=0 -> sum=8'h00, count=1; then op_a=8'h00, op_b=8'h00, cin=1 started in the DONE cycle -> sum=8'h01, count=0 with done 9 cycles later.
REQ-029 SHALL verify: start re-pulsed with op_a=8'hAA in cycle 4 of an 8'h03+8'h04 operation -> ignored; result sum=8'h07 in cycle 9.
REQ-030 SHALL verify: sys_rst_n pulsed low in cycle 5 of an operation -> all outputs 0 immediately, no done pulse, FSM in IDLE after release.
REQ-031 SHALL verify, with SERIAL_ADDER_SUB_EN: 8'h05 - 8'h07 -> sum=8'hFE, count=0; 8'h07 - 8'h05 -> sum=8'h02, count=1.
REQ-032 SHALL verify: 200 random operand/cin triples, each checked against a reference sum at done, with done asserted exactly once per accepted start.

Source files
------------

// File: rtl/serial_adder_pkg.sv
// -----------------------------------------------------------------------------
// serial_adder_pkg
//   Shared constants for the bit-serial adder controller:
//     DEFAULT_WIDTH  default operand/result width
//     state_t        FSM state type, with encodings ST_IDLE / ST_SHIFT / ST_DONE
//     cnt_bits()     width of the bit counter for a given operand width
// -----------------------------------------------------------------------------
package serial_adder_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_SHIFT = 2'd1;
  localparam state_t ST_DONE  = 2'd2;

  // The counter must be able to hold the terminal value WIDTH itself.
  function automatic int cnt_bits(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/serial_adder_ctrl_full_adder.sv
// -----------------------------------------------------------------------------
// full_adder
//   Single-bit full adder. It forms the whole arithmetic datapath of the
//   serial adder.
//   Ports:
//     in_1, in_2  addend bits
//     cin         carry in
//     sum         sum bit
//     count       carry out
// -----------------------------------------------------------------------------
module full_adder (
  input  logic in_1,
  input  logic in_2,
  input  logic cin,
  output logic sum,
  output logic count
);

  assign sum   = in_1 ^ in_2 ^ cin;
  assign count = (in_1 & in_2) | (in_1 & cin) | (in_2 & cin);

endmodule

// File: rtl/serial_adder_ctrl.sv
// -----------------------------------------------------------------------------
// serial_adder_ctrl
//   Bit-serial adder: {count,sum} = op_a + op_b + cin. The operands are
//   processed LSB first, one bit per clock, through a single full_adder.
//   Latency from the accepted start to done is WIDTH+1 cycles.
//
//   Optional macro SERIAL_ADDER_SUB_EN
//     Adds the input port sub. When sub=1 the module loads ~op_b and a carry-in
//     of 1, so it computes op_a - op_b, and count=1 means there was no borrow.
//
//   Ports:
//     sys_clk    system clock (rising edge)
//     sys_rst_n  asynchronous active-low reset
//     start      request one operation; only accepted in IDLE or DONE
//     op_a/op_b  operands, captured on the accepted start
//     cin        initial carry in, captured on the accepted start
//     sub        (SERIAL_ADDER_SUB_EN only) subtract instead of add
//     busy       high while bits are being shifted
//     done       one-cycle pulse when sum/count become valid
//     sum        result, held until the next operation completes
//     count      final carry out, held together with sum
// -----------------------------------------------------------------------------
module serial_adder_ctrl
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             count
);

  localparam int CNT_W = cnt_bits(WIDTH);

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   a_q, b_q;
  logic               carry_q;
  logic [CNT_W-1:0]   cnt_q;
  // Holds the sum bits collected so far. The final bit is merged in on the
  // completion edge, so only WIDTH-1 bits of storage are needed.
  logic [WIDTH-2:0]   res_q;
  logic [WIDTH-1:0]   sum_q;
  logic               count_q;

  logic               accept;
  logic               last_bit;
  logic               fa_sum, fa_cout;
  logic [WIDTH-1:0]   res_full;
  logic [WIDTH-1:0]   b_load;
  logic               c_load;

  assign accept   = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
  assign last_bit = (state_q == ST_SHIFT) && (cnt_q == CNT_W'(WIDTH - 1));
  assign res_full = {fa_sum, res_q};

  // Operand B and carry-in that are loaded on an accepted start.
  always_comb begin
    b_load = op_b;
    c_load = cin;
`ifdef SERIAL_ADDER_SUB_EN
    if (sub) begin
      b_load = ~op_b;
      c_load = 1'b1;
    end
`endif
  end

  full_adder u_fa (
    .in_1  (a_q[0]),
    .in_2  (b_q[0]),
    .cin   (carry_q),
    .sum   (fa_sum),
    .count (fa_cout)
  );

  // FSM: state register
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM: next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (start) state_d = ST_SHIFT;
      ST_SHIFT: if (last_bit) state_d = ST_DONE;
      ST_DONE:  state_d = start ? ST_SHIFT : ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    busy = (state_q == ST_SHIFT);
    done = (state_q == ST_DONE);
  end

  // Datapath. A start arriving during SHIFT is not accepted, so it leaves
  // the operand registers alone.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      res_q   <= '0;
      sum_q   <= '0;
      count_q <= 1'b0;
    end else if (accept) begin
      a_q     <= op_a;
      b_q     <= b_load;
      carry_q <= c_load;
      cnt_q   <= '0;
    end else if (state_q == ST_SHIFT) begin
      a_q     <= a_q >> 1;
      b_q     <= b_q >> 1;
      carry_q <= fa_cout;
      res_q   <= res_full[WIDTH-1:1];
      cnt_q   <= cnt_q + CNT_W'(1);
      // The outputs change only on completion, so they stay stable while
      // the next operation is being shifted.
      if (last_bit) begin
        sum_q   <= res_full;
        count_q <= fa_cout;
      end
    end
  end

  assign sum   = sum_q;
  assign count = count_q;

endmodule
